// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, encodings and fetch state type
package cpu_pkg;

    localparam int PC_W   = 12;
    localparam int INST_W = 16;

    typedef logic [PC_W-1:0]   pc_t;
    typedef logic [INST_W-1:0] inst_t;

    localparam inst_t      NOP_INST = 16'h0000;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef enum logic [1:0] {
        FETCH_FILL,
        FETCH_RUN,
        FETCH_HALTED
    } fetch_state_e;

    function automatic logic is_halt(input inst_t inst);
        return inst[INST_W-1:INST_W-4] == OP_HALT;
    endfunction

endpackage

// File: rtl/fetch_addr_sel.sv
// rtl/fetch_addr_sel.sv - fetch address priority mux (redirect > stall replay > pc) plus incrementer
module fetch_addr_sel
    import cpu_pkg::*;
(
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            stall,
    input  logic [PC_W-1:0] resp_pc,
    input  logic [PC_W-1:0] next_pc,
    output logic [PC_W-1:0] addr,
    output logic [PC_W-1:0] addr_inc
);

    always_comb begin
        addr = next_pc;
        if (redirect_valid) begin
            addr = redirect_pc;
        end else if (stall) begin
            // replaying the shown slot keeps imem_rdata stable across the stall
            addr = resp_pc;
        end
        addr_inc = addr + PC_W'(1);
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage feeding the fetch->decode register
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 12'h000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [PC_W-1:0]   pcF,
    output logic [INST_W-1:0] instF,
    output logic              validF
);

    fetch_state_e state_q, state_d;
    pc_t          pc_q, pc_d;
    pc_t          resp_pc_q, resp_pc_d;
    logic         resp_valid_q, resp_valid_d;

    pc_t          sel_addr, sel_addr_inc;
    logic         halt_now, advance;

    fetch_addr_sel u_addr_sel (
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .resp_pc        (resp_pc_q),
        .next_pc        (pc_q),
        .addr           (sel_addr),
        .addr_inc       (sel_addr_inc)
    );

    always_comb begin
        validF    = resp_valid_q && (state_q != FETCH_HALTED) && !redirect_valid;
        instF     = validF ? imem_rdata : NOP_INST;
        pcF       = resp_pc_q;
        // memory interface is parked while reset is held, whatever the other inputs do
        imem_req  = reset && ((state_q != FETCH_HALTED) || redirect_valid);
        imem_addr = reset ? sel_addr : RESET_PC;

        halt_now  = validF && !stall && is_halt(imem_rdata);
        advance   = redirect_valid || (!stall && (state_q != FETCH_HALTED) && !halt_now);

        state_d      = state_q;
        pc_d         = pc_q;
        resp_pc_d    = resp_pc_q;
        resp_valid_d = resp_valid_q;
        if (advance) begin
            resp_pc_d    = sel_addr;
            pc_d         = sel_addr_inc;
            resp_valid_d = 1'b1;
            state_d      = FETCH_RUN;
        end else if (halt_now) begin
            state_d = FETCH_HALTED;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= FETCH_FILL;
            pc_q         <= RESET_PC;
            resp_pc_q    <= '0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            resp_pc_q    <= resp_pc_d;
            resp_valid_q <= resp_valid_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [11:0] redirect_pc;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic [15:0] imem_rdata;
    logic [11:0] pcF;
    logic [15:0] instF;
    logic        validF;

    logic [15:0] mem [0:4095];

    int n_checks = 0;
    int n_errors = 0;

    fetch_unit #(.RESET_PC(12'h000)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .pcF            (pcF),
        .instF          (instF),
        .validF         (validF)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_req) imem_rdata <= mem[imem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_slot(input string tag, input logic [11:0] pc, input logic [15:0] inst,
                              input logic valid);
        #1;
        check({tag, ".validF"}, 32'(validF), 32'(valid));
        check({tag, ".instF"}, 32'(instF), 32'(inst));
        if (valid) check({tag, ".pcF"}, 32'(pcF), 32'(pc));
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'h1000 + 16'(i);
        imem_rdata     = 16'h0;
        reset          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 12'h000;

        // reset values, with redirect/stall asserted to show they are ignored
        tick();
        stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 12'h123;
        #1;
        check("rst.pcF", 32'(pcF), 32'h000);
        check("rst.instF", 32'(instF), 32'h0000);
        check("rst.validF", 32'(validF), 32'h0);
        check("rst.imem_req", 32'(imem_req), 32'h0);
        check("rst.imem_addr", 32'(imem_addr), 32'h000);
        tick();
        stall = 1'b0; redirect_valid = 1'b0;

        // release: one FILL bubble, then sequential fetch
        tick();
        reset = 1'b1;
        #1;
        check("fill.validF", 32'(validF), 32'h0);
        check("fill.imem_req", 32'(imem_req), 32'h1);
        check("fill.imem_addr", 32'(imem_addr), 32'h000);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_slot("seq", 12'(i), 16'h1000 + 16'(i), 1'b1);
        end

        // three stall cycles on slot 005, then the release cycle still shows 005
        for (int i = 0; i < 4; i++) begin
            tick();
            stall = (i < 3);
            check_slot("stall", 12'h005, 16'h1005, 1'b1);
            if (i < 3) check("stall.imem_addr", 32'(imem_addr), 32'h005);
        end
        check("stall_rel.imem_addr", 32'(imem_addr), 32'h006);
        for (int i = 6; i <= 15; i++) begin
            tick();
            check_slot("post_stall", 12'(i), 16'h1000 + 16'(i), 1'b1);
        end

        // redirect while pcF=010
        tick();
        redirect_valid = 1'b1; redirect_pc = 12'h0A0;
        #1;
        check("redir.pcF_shown", 32'(pcF), 32'h010);
        check_slot("redir.squash", 12'h010, 16'h0000, 1'b0);
        check("redir.imem_addr", 32'(imem_addr), 32'h0A0);
        tick();
        redirect_valid = 1'b0;
        check_slot("redir.t0", 12'h0A0, 16'h10A0, 1'b1);
        tick();
        check_slot("redir.t1", 12'h0A1, 16'h10A1, 1'b1);

        // redirect and stall together: redirect wins
        tick();
        redirect_valid = 1'b1; redirect_pc = 12'h030; stall = 1'b1;
        check_slot("rs.squash", 12'h0A2, 16'h0000, 1'b0);
        tick();
        redirect_valid = 1'b0; stall = 1'b0;
        check_slot("rs.t0", 12'h030, 16'h1030, 1'b1);

        // HALT at 004
        mem[4] = 16'hF000;
        tick();
        redirect_valid = 1'b1; redirect_pc = 12'h002;
        tick();
        redirect_valid = 1'b0;
        check_slot("h.002", 12'h002, 16'h1002, 1'b1);
        tick();
        check_slot("h.003", 12'h003, 16'h1003, 1'b1);
        tick();
        check_slot("h.halt", 12'h004, 16'hF000, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_slot("halted", 12'h000, 16'h0000, 1'b0);
            check("halted.imem_req", 32'(imem_req), 32'h0);
        end
        tick();
        redirect_valid = 1'b1; redirect_pc = 12'h012;
        #1;
        check("resume.imem_req", 32'(imem_req), 32'h1);
        check("resume.imem_addr", 32'(imem_addr), 32'h012);
        tick();
        redirect_valid = 1'b0;
        check_slot("resume.t0", 12'h012, 16'h1012, 1'b1);
        tick();
        check_slot("resume.t1", 12'h013, 16'h1013, 1'b1);

        // PC wrap
        tick();
        redirect_valid = 1'b1; redirect_pc = 12'hFFE;
        tick();
        redirect_valid = 1'b0;
        check_slot("wrap.ffe", 12'hFFE, 16'h1FFE, 1'b1);
        tick();
        check_slot("wrap.fff", 12'hFFF, 16'h1FFF, 1'b1);
        tick();
        check_slot("wrap.000", 12'h000, 16'h1000, 1'b1);
        tick();
        check_slot("wrap.001", 12'h001, 16'h1001, 1'b1);

        // reset mid-run takes effect without a clock edge
        reset = 1'b0;
        #1;
        check("mid_rst.pcF", 32'(pcF), 32'h000);
        check("mid_rst.validF", 32'(validF), 32'h0);
        check("mid_rst.instF", 32'(instF), 32'h0000);
        check("mid_rst.imem_req", 32'(imem_req), 32'h0);
        check("mid_rst.imem_addr", 32'(imem_addr), 32'h000);
        tick();
        tick();
        reset = 1'b1;
        check_slot("refill", 12'h000, 16'h0000, 1'b0);
        tick();
        check_slot("refill.t0", 12'h000, 16'h1000, 1'b1);
        tick();
        check_slot("refill.t1", 12'h001, 16'h1001, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
